uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter SHALL be: SYNC_STAGES, default 2, number of flip-flops in the rx_line synchronizer (minimum 2).
REQ-002 Port clk  input  1  system clock; all state SHALL change on its rising edge.
REQ-003 Port rst_n  input  1  reset; the block SHALL use one clock, and reset SHALL be asynchronous and active-low.
REQ-004 Port baud_tick_16x  input  1  one-clk-wide enable from baud_gen_16x at 16x the bit rate.
REQ-005 Port rx_line  input  1  asynchronous serial input, idle high, 8N1, LSB first.
REQ-006 Port rx_data  output  8  last successfully received byte.
REQ-007 Port rx_valid  output  1  one-clk pulse marking a new byte on rx_data.
REQ-008 Port frame_err  output  1  one-clk pulse marking a frame with stop bit = 0.
REQ-009 Port rx_busy  output  1  high while a frame is in progress (state not IDLE).

Function
REQ-010 rx_line SHALL pass through a SYNC_STAGES-deep synchronizer; all decisions SHALL use the synchronized value (rx_s).
REQ-011 State, counters and sampling SHALL advance only in clk cycles where baud_tick_16x = 1; rx_valid/frame_err pulses are the only exceptions (see REQ-018).
REQ-012 FSM states SHALL be IDLE, START, DATA, STOP; 4-bit tick counter (tcnt) and 3-bit bit index (bidx).
REQ-013 IDLE: an "armed" flag SHALL set when rx_s = 1 on a tick; when armed and rx_s = 0 on a tick -> START, tcnt = 0, armed cleared.
REQ-014 START: tcnt increments per tick; on the tick where tcnt = 7 (mid start bit) rx_s SHALL be sampled: 0 -> DATA, tcnt = 0, bidx = 0; 1 -> IDLE (glitch rejected, no output pulse).
REQ-015 DATA: on the tick where tcnt = 15, rx_s SHALL be shifted into bit 7 of the shift register (shift right, LSB first), tcnt wraps to 0; after bidx = 7 sample -> STOP, otherwise bidx increments.
REQ-016 STOP: on the tick where tcnt = 15, rx_s sampled: 1 -> rx_data <= shift register, rx_valid pulse; 0 -> frame_err pulse, rx_data unchanged; both cases -> IDLE.
REQ-017 After a frame error, a new start SHALL NOT be detected until rx_s has been seen high on at least one tick (arming rule, REQ-013), so a held-low break produces exactly one frame_err.
REQ-018 rx_valid and frame_err SHALL be registered, asserted for exactly one clk in the cycle after the stop-sample tick, never simultaneously.
REQ-019 rx_data SHALL hold stable until the next successful frame; no consumer handshake exists; a byte not consumed is overwritten (no overrun flag).
REQ-020 Latency: rx_valid SHALL assert 1 clk after the tick 8+16*8+16 = 152 ticks after the tick that detected the start edge.
REQ-021 rx_busy SHALL be combinationally (state != IDLE).
REQ-022 Back-to-back frames (stop bit immediately followed by a start bit) SHALL be received without loss: IDLE is armed by the high stop bit.

Reset
REQ-023 On rst_n = 0 asynchronously: state = IDLE, armed = 0, tcnt = 0, bidx = 0, shift register = 0x00, rx_data = 0x00, rx_valid = 0, frame_err = 0, rx_busy = 0, synchronizer flops = 1.
REQ-024 Reset asserted mid-frame SHALL abort the frame with no pulse; after release, reception SHALL restart only after rx_s is seen high (armed) and then low.

Verification
REQ-025 Loopback: uart_tx tx_line -> rx_line, shared counter/baud_gen_16x, baud_div = 5, send 0xA5 -> exactly one rx_valid, rx_data = 0xA5, frame_err never 1.
REQ-026 Glitch: rx_line low for 4 ticks then high -> state returns to IDLE, rx_valid = 0, frame_err = 0, rx_data unchanged.
REQ-027 Frame error: drive 0x3C with stop bit = 0, then hold low for 3 frame times -> one frame_err pulse, no rx_valid, rx_data unchanged; after line returns high, a following 0x5A frame -> rx_valid, rx_data = 0x5A.
REQ-028 Back-to-back: 0x00 then 0xFF with no idle gap -> two rx_valid pulses, rx_data = 0x00 then 0xFF.
REQ-029 Reset mid-frame: assert rst_n = 0 during bit 3 of 0x81 -> all outputs 0 immediately; no pulse; next full frame 0x81 -> rx_data = 0x81.

Source files
------------

// File: rtl/uart_rx.sv
// UART receiver, 8N1, LSB first, oversampled at 16x the bit rate.
//
// Ports:
//   clk            system clock, all state changes on its rising edge
//   rst_n          asynchronous active-low reset
//   baud_tick_16x  one-clk enable at 16x the bit rate
//   rx_line        asynchronous serial input, idle high
//   rx_data        last successfully received byte (held until the next good frame)
//   rx_valid       one-clk pulse: new byte on rx_data
//   frame_err      one-clk pulse: frame ended with a low stop bit
//   rx_busy        high while a frame is in progress
module uart_rx #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       baud_tick_16x,
   input  logic       rx_line,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       frame_err,
   output logic       rx_busy
);

   typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   rx_s;

   state_e     state_q, state_d;
   logic       armed_q, armed_d;
   logic [3:0] tcnt_q, tcnt_d;
   logic [2:0] bidx_q, bidx_d;
   logic [7:0] shift_q, shift_d;
   logic [7:0] data_q, data_d;
   logic       valid_q, valid_d;
   logic       ferr_q, ferr_d;

   // Synchronizer resets to idle-high so reset release never looks like a start edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '1;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], rx_line};
      end
   end

   assign rx_s = sync_q[SYNC_STAGES-1];

   always_comb begin
      state_d = state_q;
      armed_d = armed_q;
      tcnt_d  = tcnt_q;
      bidx_d  = bidx_q;
      shift_d = shift_q;
      data_d  = data_q;
      valid_d = 1'b0;
      ferr_d  = 1'b0;

      if (baud_tick_16x) begin
         unique case (state_q)
            StIdle: begin
               // A start edge counts only after the line has been seen high, so a
               // held-low break cannot retrigger reception.
               if (rx_s) begin
                  armed_d = 1'b1;
               end else if (armed_q) begin
                  state_d = StStart;
                  tcnt_d  = 4'd0;
                  armed_d = 1'b0;
               end
            end
            StStart: begin
               if (tcnt_q == 4'd7) begin
                  if (!rx_s) begin
                     state_d = StData;
                     tcnt_d  = 4'd0;
                     bidx_d  = 3'd0;
                  end else begin
                     state_d = StIdle;  // glitch shorter than half a bit
                     tcnt_d  = 4'd0;
                  end
               end else begin
                  tcnt_d = tcnt_q + 4'd1;
               end
            end
            StData: begin
               if (tcnt_q == 4'd15) begin
                  shift_d = {rx_s, shift_q[7:1]};
                  tcnt_d  = 4'd0;
                  if (bidx_q == 3'd7) begin
                     state_d = StStop;
                  end else begin
                     bidx_d = bidx_q + 3'd1;
                  end
               end else begin
                  tcnt_d = tcnt_q + 4'd1;
               end
            end
            StStop: begin
               if (tcnt_q == 4'd15) begin
                  state_d = StIdle;
                  tcnt_d  = 4'd0;
                  if (rx_s) begin
                     data_d  = shift_q;
                     valid_d = 1'b1;
                     armed_d = 1'b1;  // high stop bit arms back-to-back reception
                  end else begin
                     ferr_d  = 1'b1;
                     armed_d = 1'b0;
                  end
               end else begin
                  tcnt_d = tcnt_q + 4'd1;
               end
            end
            default: begin
               state_d = StIdle;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         armed_q <= 1'b0;
         tcnt_q  <= 4'd0;
         bidx_q  <= 3'd0;
         shift_q <= 8'h00;
         data_q  <= 8'h00;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         armed_q <= armed_d;
         tcnt_q  <= tcnt_d;
         bidx_q  <= bidx_d;
         shift_q <= shift_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         ferr_q  <= ferr_d;
      end
   end

   assign rx_data   = data_q;
   assign rx_valid  = valid_q;
   assign frame_err = ferr_q;
   assign rx_busy   = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: table-driven frames, hand-written corner
// sequences (latency, glitch, break, back-to-back, mid-frame reset) and random
// frames checked against a frame-level reference model.
module tb_uart_rx;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       tick_16x = 1'b0;
   logic       rx_line = 1'b1;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       frame_err;
   logic       rx_busy;

   int unsigned n_vec = 0;
   int unsigned n_err = 0;
   int          valid_cnt = 0;
   int          ferr_cnt = 0;
   logic [7:0]  got_q[$];
   logic        prev_valid = 1'b0;
   logic [1:0]  div = 2'd0;

   typedef struct {
      logic [7:0] data;
      logic       stop;
      int         gap;
      int         exp_v;
      int         exp_f;
      logic [7:0] exp_data;
   } vec_t;

   vec_t       vecs[7];
   int         v0, f0, ticks;
   logic [7:0] last_good;
   logic [7:0] rb;
   logic       rs;
   int         rg;

   uart_rx #(.SYNC_STAGES(2)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .baud_tick_16x(tick_16x),
      .rx_line      (rx_line),
      .rx_data      (rx_data),
      .rx_valid     (rx_valid),
      .frame_err    (frame_err),
      .rx_busy      (rx_busy)
   );

   always #5 clk = ~clk;

   // One tick every 4 clocks.
   always @(posedge clk) begin
      div      <= div + 2'd1;
      tick_16x <= (div == 2'd3);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Pulse monitor: counts pulses, logs bytes, checks exclusivity and width.
   always @(negedge clk) begin
      if (rx_valid || frame_err) check("pulse_exclusive", {31'b0, rx_valid & frame_err}, 0);
      if (rx_valid) begin
         check("valid_width", {31'b0, prev_valid}, 0);
         valid_cnt++;
         got_q.push_back(rx_data);
      end
      if (frame_err) ferr_cnt++;
      prev_valid = rx_valid;
   end

   task automatic hold(input logic v, input int n);
      rx_line = v;
      repeat (n) @(posedge tick_16x);
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop, input int gap);
      hold(1'b0, 16);
      for (int i = 0; i < 8; i++) hold(b[i], 16);
      hold(stop, 16);
      hold(1'b1, gap);
   endtask

   initial begin
      vecs[0] = '{8'hA5, 1'b1, 4, 1, 0, 8'hA5};
      vecs[1] = '{8'h00, 1'b1, 0, 1, 0, 8'h00};
      vecs[2] = '{8'hFF, 1'b1, 2, 1, 0, 8'hFF};
      vecs[3] = '{8'h3C, 1'b0, 4, 0, 1, 8'hFF};
      vecs[4] = '{8'h5A, 1'b1, 3, 1, 0, 8'h5A};
      vecs[5] = '{8'h01, 1'b1, 0, 1, 0, 8'h01};
      vecs[6] = '{8'h80, 1'b1, 5, 1, 0, 8'h80};

      // Reset values
      repeat (3) @(posedge clk);
      #1;
      check("reset_data", {24'b0, rx_data}, 0);
      check("reset_valid", {31'b0, rx_valid}, 0);
      check("reset_ferr", {31'b0, frame_err}, 0);
      check("reset_busy", {31'b0, rx_busy}, 0);
      rst_n = 1'b1;
      repeat (4) @(posedge tick_16x);

      // Latency: valid in the cycle after the 153rd tick from the start drive
      v0 = valid_cnt;
      fork
         send_frame(8'hC3, 1'b1, 4);
         begin
            ticks = 0;
            @(negedge clk);
            for (int i = 0; i < 3000; i++) begin
               @(negedge clk);
               if (tick_16x) ticks++;
               if (rx_valid) break;
            end
         end
      join
      check("latency_ticks", ticks, 153);
      check("latency_count", valid_cnt - v0, 1);
      check("latency_data", {24'b0, rx_data}, 32'hC3);

      // Table of frames
      for (int i = 0; i < 7; i++) begin
         v0 = valid_cnt;
         f0 = ferr_cnt;
         send_frame(vecs[i].data, vecs[i].stop, vecs[i].gap);
         check("tbl_valid", valid_cnt - v0, vecs[i].exp_v);
         check("tbl_ferr", ferr_cnt - f0, vecs[i].exp_f);
         check("tbl_data", {24'b0, rx_data}, {24'b0, vecs[i].exp_data});
      end
      last_good = 8'h80;

      // Glitch: 4 ticks low then high
      v0 = valid_cnt;
      f0 = ferr_cnt;
      hold(1'b0, 4);
      @(negedge clk);
      check("glitch_busy_on", {31'b0, rx_busy}, 1);
      hold(1'b1, 30);
      check("glitch_busy_off", {31'b0, rx_busy}, 0);
      check("glitch_valid", valid_cnt - v0, 0);
      check("glitch_ferr", ferr_cnt - f0, 0);
      check("glitch_data", {24'b0, rx_data}, {24'b0, last_good});

      // Frame error followed by a long break, then a good frame
      v0 = valid_cnt;
      f0 = ferr_cnt;
      send_frame(8'h3C, 1'b0, 0);
      hold(1'b0, 480);
      hold(1'b1, 20);
      check("break_ferr", ferr_cnt - f0, 1);
      check("break_valid", valid_cnt - v0, 0);
      check("break_data", {24'b0, rx_data}, {24'b0, last_good});
      v0 = valid_cnt;
      send_frame(8'h5A, 1'b1, 4);
      check("after_break_valid", valid_cnt - v0, 1);
      check("after_break_data", {24'b0, rx_data}, 32'h5A);

      // Back-to-back 0x00 then 0xFF
      v0 = valid_cnt;
      send_frame(8'h00, 1'b1, 0);
      send_frame(8'hFF, 1'b1, 4);
      check("b2b_count", valid_cnt - v0, 2);
      if (got_q.size() >= 2) begin
         check("b2b_first", {24'b0, got_q[got_q.size()-2]}, 32'h00);
         check("b2b_second", {24'b0, got_q[got_q.size()-1]}, 32'hFF);
      end

      // Reset in the middle of bit 3 of 0x81
      v0 = valid_cnt;
      f0 = ferr_cnt;
      fork
         send_frame(8'h81, 1'b1, 4);
         begin
            repeat (72) @(posedge tick_16x);
            @(negedge clk);
            check("midrst_busy_before", {31'b0, rx_busy}, 1);
            rst_n = 1'b0;
            #1;
            check("midrst_data", {24'b0, rx_data}, 0);
            check("midrst_valid", {31'b0, rx_valid}, 0);
            check("midrst_ferr", {31'b0, frame_err}, 0);
            check("midrst_busy", {31'b0, rx_busy}, 0);
            repeat (2) @(negedge clk);
            rst_n = 1'b1;
         end
      join
      hold(1'b1, 4);
      check("midrst_no_valid", valid_cnt - v0, 0);
      check("midrst_no_ferr", ferr_cnt - f0, 0);
      v0 = valid_cnt;
      send_frame(8'h81, 1'b1, 4);
      check("midrst_next_valid", valid_cnt - v0, 1);
      check("midrst_next_data", {24'b0, rx_data}, 32'h81);
      last_good = 8'h81;

      // Random frames against a frame-level model
      for (int i = 0; i < 20; i++) begin
         rb = 8'($urandom);
         rs = ($urandom_range(0, 7) != 0);
         rg = rs ? int'($urandom_range(0, 3)) : int'($urandom_range(2, 5));
         v0 = valid_cnt;
         f0 = ferr_cnt;
         send_frame(rb, rs, rg);
         if (rs) last_good = rb;
         check("rnd_valid", valid_cnt - v0, rs ? 1 : 0);
         check("rnd_ferr", ferr_cnt - f0, rs ? 0 : 1);
         check("rnd_data", {24'b0, rx_data}, {24'b0, last_good});
      end

      hold(1'b1, 4);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
